// File: rtl/float_discr_result_fifo.sv
// Result FIFO behind a floating-point discriminant unit: stores {res, roots, err}
// and optionally gates upstream issue with credits (FLOAT_DISCR_FIFO_CREDIT_EN).
module float_discr_result_fifo #(
  parameter int FLEN  = 64,
  parameter int NE    = 11,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arg_issue,
  input  logic            res_vld,
  input  logic [FLEN-1:0] res,
  input  logic            res_negative,
  input  logic            err,
  output logic            issue_allow,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [FLEN-1:0] out_res,
  output logic [1:0]      out_roots,
  output logic            out_err,
  output logic            overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int NM = FLEN - 1 - NE;

  // Real-root count from the sign/class of the discriminant.
  function automatic logic [1:0] calc_roots(input logic [FLEN-1:0] v,
                                            input logic neg, input logic e);
    logic [1:0] r;
    if (e) begin
      r = 2'd0;
    end else if (neg) begin
      r = 2'd0;
    end else if ((v[FLEN-2 -: NE] == {NE{1'b0}}) && (v[NM-1:0] == {NM{1'b0}})) begin
      r = 2'd1;
    end else begin
      r = 2'd2;
    end
    return r;
  endfunction

  logic [FLEN-1:0] mem_res_q   [DEPTH];
  logic [1:0]      mem_roots_q [DEPTH];
  logic            mem_err_q   [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          ovf_q, ovf_d;

  logic push_s, pop_s, full_s, wr_en_s, drop_s, ovf_set_s, issue_allow_s;

`ifdef FLOAT_DISCR_FIFO_CREDIT_EN
  localparam int IW = AW + 2;
  localparam int SW = AW + 3;
  logic [IW-1:0] in_flight_q, in_flight_d;

  // Credit accounting: upstream may issue only while stored plus pending results fit.
  always_comb begin
    in_flight_d   = in_flight_q;
    issue_allow_s = (SW'(occ_q) + SW'(in_flight_q)) < SW'(DEPTH);
    case ({arg_issue, res_vld})
      2'b10: begin
        if (in_flight_q != {IW{1'b1}}) begin
          in_flight_d = in_flight_q + IW'(1);
        end else begin
          in_flight_d = in_flight_q;
        end
      end
      2'b01: begin
        if (in_flight_q != {IW{1'b0}}) begin
          in_flight_d = in_flight_q - IW'(1);
        end else begin
          in_flight_d = in_flight_q;
        end
      end
      default: in_flight_d = in_flight_q;
    endcase
  end

  // In-flight counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight_q <= {IW{1'b0}};
    end else begin
      in_flight_q <= in_flight_d;
    end
  end

  assign ovf_set_s = drop_s | (arg_issue & ~issue_allow_s);
`else
  logic unused_arg_issue_s;
  assign unused_arg_issue_s = arg_issue;
  assign issue_allow_s      = 1'b1;
  assign ovf_set_s          = drop_s;
`endif

  assign push_s  = res_vld & ~rst;
  assign full_s  = (occ_q == OW'(DEPTH));
  assign pop_s   = out_vld & out_rdy;
  // At full a concurrent pop frees the slot the write lands in.
  assign wr_en_s = push_s & (~full_s | pop_s);
  assign drop_s  = push_s & full_s & ~pop_s;

  // Pointer, occupancy and sticky overflow next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q | ovf_set_s;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, pop_s})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      occ_q    <= {OW{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_res_q[wr_ptr_q]   <= res;
      mem_roots_q[wr_ptr_q] <= calc_roots(res, res_negative, err);
      mem_err_q[wr_ptr_q]   <= err;
    end else begin
      mem_res_q[wr_ptr_q]   <= mem_res_q[wr_ptr_q];
      mem_roots_q[wr_ptr_q] <= mem_roots_q[wr_ptr_q];
      mem_err_q[wr_ptr_q]   <= mem_err_q[wr_ptr_q];
    end
  end

  assign out_vld     = (occ_q != {OW{1'b0}});
  assign out_res     = mem_res_q[rd_ptr_q];
  assign out_roots   = mem_roots_q[rd_ptr_q];
  assign out_err     = mem_err_q[rd_ptr_q];
  assign overflow    = ovf_q;
  assign issue_allow = issue_allow_s;

endmodule

// File: tb/tb_float_discr_result_fifo.sv
// Directed scoreboard bench for float_discr_result_fifo (DEPTH=4, FLEN=64).
module tb_float_discr_result_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arg_issue = 1'b0;
  logic        res_vld = 1'b0;
  logic [63:0] res = 64'd0;
  logic        res_negative = 1'b0;
  logic        err = 1'b0;
  logic        issue_allow;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [63:0] out_res;
  logic [1:0]  out_roots;
  logic        out_err;
  logic        overflow;

  typedef struct packed {
    logic [63:0] res;
    logic [1:0]  roots;
    logic        err;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_ovf = 1'b0;

  localparam logic [63:0] D_4P0  = 64'h4010_0000_0000_0000;
  localparam logic [63:0] D_P0   = 64'h0000_0000_0000_0000;
  localparam logic [63:0] D_N0   = 64'h8000_0000_0000_0000;
  localparam logic [63:0] D_N8   = 64'hC020_0000_0000_0000;
  localparam logic [63:0] D_INF  = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] D_NAN  = 64'h7FF8_0000_0000_0001;
  localparam logic [63:0] D_1P5  = 64'h3FF8_0000_0000_0000;
  localparam logic [63:0] D_DEN  = 64'h0000_0000_0000_0001;

  float_discr_result_fifo dut (
    .clk(clk), .rst(rst), .arg_issue(arg_issue), .res_vld(res_vld), .res(res),
    .res_negative(res_negative), .err(err), .issue_allow(issue_allow),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_res(out_res), .out_roots(out_roots),
    .out_err(out_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] model_roots(input logic [63:0] v, input logic n, input logic e);
    logic [10:0] ex;
    logic [51:0] mn;
    ex = v[62:52];
    mn = v[51:0];
    if (e || n) return 2'd0;
    return ((ex == 11'd0) && (mn == 52'd0)) ? 2'd1 : 2'd2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push one result with out_rdy held low; the model decides whether it is kept.
  task automatic push(input logic [63:0] v, input logic n, input logic e);
    ent_t x;
    res = v; res_negative = n; err = e; res_vld = 1'b1;
    x.res = v; x.roots = model_roots(v, n, e); x.err = e;
    if (sb.size() < 4) sb.push_back(x);
    else exp_ovf = 1'b1;
    step();
    res_vld = 1'b0; res_negative = 1'b0; err = 1'b0;
  endtask

  task automatic check_head(input string tag);
    chk({tag, "_vld"}, 64'(out_vld), 64'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      chk({tag, "_res"}, out_res, sb[0].res);
      chk({tag, "_roots"}, 64'(out_roots), 64'(sb[0].roots));
      chk({tag, "_err"}, 64'(out_err), 64'(sb[0].err));
    end
  endtask

  task automatic pop_check(input string tag);
    check_head(tag);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  initial begin
    ent_t f;
    // Reset state
    repeat (2) step();
    rst = 1'b0;
    chk("rst_vld", 64'(out_vld), 64'd0);
    chk("rst_allow", 64'(issue_allow), 64'd1);
    chk("rst_ovf", 64'(overflow), 64'd0);

    // 4.0 with consumer ready: visible next cycle, then popped
    out_rdy = 1'b1;
    push(D_4P0, 1'b0, 1'b0);
    check_head("four");
    step();
    void'(sb.pop_front());
    out_rdy = 1'b0;
    chk("four_drained", 64'(out_vld), 64'd0);

    // Signed zeros give one root
    push(D_P0, 1'b0, 1'b0);
    push(D_N0, 1'b0, 1'b0);
    pop_check("pzero");
    pop_check("nzero");

    // Negative, inf, NaN, normal and denormal positive
    push(D_N8, 1'b1, 1'b0);
    push(D_INF, 1'b0, 1'b1);
    push(D_NAN, 1'b0, 1'b1);
    push(D_1P5, 1'b0, 1'b0);
    pop_check("neg8");
    pop_check("inf");
    pop_check("nan");
    pop_check("one5");
    push(D_DEN, 1'b0, 1'b0);
    pop_check("denorm");
    chk("class_empty", 64'(out_vld), 64'd0);

`ifdef FLOAT_DISCR_FIFO_CREDIT_EN
    // Credits exhausted by issues, then by stored results, then freed by a pop
    repeat (4) begin
      arg_issue = 1'b1;
      step();
      arg_issue = 1'b0;
    end
    chk("cr_allow0", 64'(issue_allow), 64'd0);
    push(64'h4000_0000_0000_0000, 1'b0, 1'b0);
    push(64'h4008_0000_0000_0000, 1'b0, 1'b0);
    push(64'h4014_0000_0000_0000, 1'b0, 1'b0);
    push(64'h4018_0000_0000_0000, 1'b0, 1'b0);
    chk("cr_allow_full", 64'(issue_allow), 64'd0);
    pop_check("cr_pop0");
    chk("cr_allow1", 64'(issue_allow), 64'd1);
    chk("cr_ovf", 64'(overflow), 64'd0);
    pop_check("cr_pop1");
    pop_check("cr_pop2");
    pop_check("cr_pop3");
`endif

    // Fill, drop the fifth, then push and pop together at full
    push(64'h3FF0_0000_0000_0000, 1'b0, 1'b0);
    push(64'hBFF0_0000_0000_0000, 1'b1, 1'b0);
    push(64'h4020_0000_0000_0000, 1'b0, 1'b0);
    push(64'h4024_0000_0000_0000, 1'b0, 1'b0);
    chk("full_ovf0", 64'(overflow), 64'd0);
`ifndef FLOAT_DISCR_FIFO_CREDIT_EN
    chk("nocr_allow", 64'(issue_allow), 64'd1);
`endif
    push(64'h4030_0000_0000_0000, 1'b0, 1'b0);
    chk("drop_ovf", 64'(overflow), 64'(exp_ovf));
    check_head("full_head");
    res = 64'h4040_0000_0000_0000; res_vld = 1'b1; out_rdy = 1'b1;
    step();
    res_vld = 1'b0; out_rdy = 1'b0;
    void'(sb.pop_front());
    f.res = 64'h4040_0000_0000_0000; f.roots = 2'd2; f.err = 1'b0;
    sb.push_back(f);
    pop_check("ord1");
    pop_check("ord2");
    pop_check("ord3");
    pop_check("ord4");
    chk("ord_empty", 64'(out_vld), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Reset mid-operation with stored and in-flight results
    push(D_4P0, 1'b0, 1'b0);
    push(D_1P5, 1'b0, 1'b0);
    arg_issue = 1'b1;
    step();
    arg_issue = 1'b0;
    rst = 1'b1; res_vld = 1'b1; res = D_N8;
    step();
    rst = 1'b0; res_vld = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    chk("mid_rst_vld", 64'(out_vld), 64'd0);
    chk("mid_rst_allow", 64'(issue_allow), 64'd1);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    push(64'h4050_0000_0000_0000, 1'b0, 1'b0);
    pop_check("late");
    chk("late_empty", 64'(out_vld), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
